// File: rtl/iob_ahb2axis_pkg.sv
// Shared encodings for the AHB-to-AXI-Stream bridge.
// Define IOB_AHB2AXIS_ERR_EN to enable ERROR responses for illegal accesses.
package iob_ahb2axis_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] OFF_DATA      = 2'd0;
    localparam logic [1:0] OFF_DATA_LAST = 2'd1;
    localparam logic [1:0] OFF_STATUS    = 2'd2;
    localparam logic [1:0] OFF_RSVD      = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam int STAT_IN_VALID = 0;
    localparam int STAT_OUT_FULL = 1;
    localparam int STAT_IN_LAST  = 2;

    // HSIZE encoding of a full data-bus word
    function automatic logic [2:0] word_hsize(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/iob_ahb2axis_if.sv
// AHB subordinate port plus outgoing/incoming AXI-Stream ports of the bridge.
// The slave modport is the bridge's view; master is the surrounding system's view.
interface iob_ahb2axis_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  s_ahb_sel_i;
    logic [ADDR_WIDTH-1:0] s_ahb_addr_i;
    logic [1:0]            s_ahb_trans_i;
    logic                  s_ahb_write_i;
    logic [2:0]            s_ahb_size_i;
    logic [DATA_WIDTH-1:0] s_ahb_wdata_i;
    logic [STRB_WIDTH-1:0] s_ahb_wstrb_i;
    logic                  s_ahb_ready_i;
    logic                  s_ahb_readyout_o;
    logic                  s_ahb_resp_o;
    logic [DATA_WIDTH-1:0] s_ahb_rdata_o;

    logic                  out_axis_tvalid_o;
    logic                  out_axis_tready_i;
    logic [DATA_WIDTH-1:0] out_axis_tdata_o;
    logic                  out_axis_tlast_o;

    logic                  in_axis_tvalid_i;
    logic                  in_axis_tready_o;
    logic [DATA_WIDTH-1:0] in_axis_tdata_i;
    logic                  in_axis_tlast_i;

    modport slave (
        input  s_ahb_sel_i, s_ahb_addr_i, s_ahb_trans_i, s_ahb_write_i,
        input  s_ahb_size_i, s_ahb_wdata_i, s_ahb_wstrb_i, s_ahb_ready_i,
        output s_ahb_readyout_o, s_ahb_resp_o, s_ahb_rdata_o,
        output out_axis_tvalid_o, out_axis_tdata_o, out_axis_tlast_o,
        input  out_axis_tready_i,
        input  in_axis_tvalid_i, in_axis_tdata_i, in_axis_tlast_i,
        output in_axis_tready_o
    );

    modport master (
        output s_ahb_sel_i, s_ahb_addr_i, s_ahb_trans_i, s_ahb_write_i,
        output s_ahb_size_i, s_ahb_wdata_i, s_ahb_wstrb_i, s_ahb_ready_i,
        input  s_ahb_readyout_o, s_ahb_resp_o, s_ahb_rdata_o,
        input  out_axis_tvalid_o, out_axis_tdata_o, out_axis_tlast_o,
        output out_axis_tready_i,
        output in_axis_tvalid_i, in_axis_tdata_i, in_axis_tlast_i,
        input  in_axis_tready_o
    );
endinterface

// File: rtl/iob_ahb2axis_obuf.sv
// One-entry registered AXI-Stream output buffer with load/drain and a full flag.
module iob_ahb2axis_obuf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  cke,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tlast,
    output logic                  full
);

    // A load in the same cycle as a drain simply replaces the departing beat
    always_ff @(posedge clock) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (cke) begin
            if (load) begin
                tvalid <= 1'b1;
                tdata  <= load_data;
                tlast  <= load_last;
            end else if (tvalid && tready) begin
                tvalid <= 1'b0;
            end
        end
    end

    assign full = tvalid;

endmodule

// File: rtl/iob_ahb2axis.sv
// AHB subordinate that pushes written words onto out_axis and pops in_axis on reads.
// Define IOB_AHB2AXIS_ERR_EN to answer illegal accesses with a two-cycle ERROR.
module iob_ahb2axis #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic          clk_i,
    input  logic          cke_i,
    input  logic          rst_i,
    iob_ahb2axis_if.slave bus
);
    import iob_ahb2axis_pkg::*;

    state_e                state_q;
    state_e                state_d;
    logic [1:0]            off_q;
    logic                  accept;
    logic                  addr_err;
    logic                  readyout;
    logic                  resp;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  pop_phase;
    logic                  load;
    logic                  is_data;
    logic                  obuf_full;
    logic [DATA_WIDTH-1:0] status_word;
    logic [ADDR_WIDTH-1:0] addr_full;
    logic [STRB_WIDTH-1:0] wstrb_unused;
    logic                  unused_bits;

    assign addr_full    = bus.s_ahb_addr_i;
    assign wstrb_unused = bus.s_ahb_wstrb_i;
    assign unused_bits  = ^{addr_full[ADDR_WIDTH-1:4], addr_full[1:0],
                            wstrb_unused, bus.s_ahb_size_i};

    assign accept = bus.s_ahb_sel_i && bus.s_ahb_ready_i &&
                    ((bus.s_ahb_trans_i == HTRANS_NONSEQ) ||
                     (bus.s_ahb_trans_i == HTRANS_SEQ));

`ifdef IOB_AHB2AXIS_ERR_EN
    assign addr_err = (bus.s_ahb_size_i != word_hsize(DATA_WIDTH)) ||
                      (bus.s_ahb_write_i && ((addr_full[3:2] == OFF_STATUS) ||
                                             (addr_full[3:2] == OFF_RSVD))) ||
                      (!bus.s_ahb_write_i && (addr_full[3:2] == OFF_RSVD));
`else
    assign addr_err = 1'b0;
`endif

    assign is_data = (off_q == OFF_DATA) || (off_q == OFF_DATA_LAST);

    always_comb begin
        status_word = '0;
        status_word[STAT_IN_VALID] = bus.in_axis_tvalid_i;
        status_word[STAT_OUT_FULL] = obuf_full;
        status_word[STAT_IN_LAST]  = bus.in_axis_tlast_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            off_q   <= OFF_DATA;
        end else if (cke_i) begin
            state_q <= state_d;
            if (readyout && accept) begin
                off_q <= addr_full[3:2];
            end
        end
    end

    // Data-phase response plus next state; a completing phase may hand straight to the next transfer
    always_comb begin
        state_d   = state_q;
        readyout  = 1'b1;
        resp      = HRESP_OKAY;
        rdata     = '0;
        pop_phase = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_WDATA: begin
                if (is_data) begin
                    readyout = ~obuf_full | bus.out_axis_tready_i;
                    load     = readyout;
                end
            end
            ST_RDATA: begin
                case (off_q)
                    OFF_DATA, OFF_DATA_LAST: begin
                        readyout  = bus.in_axis_tvalid_i;
                        pop_phase = 1'b1;
                        rdata     = bus.in_axis_tdata_i;
                    end
                    OFF_STATUS: rdata = status_word;
                    OFF_RSVD:   rdata = '0;
                    default:    rdata = '0;
                endcase
            end
            ST_ERR1: begin
                readyout = 1'b0;
                resp     = HRESP_ERROR;
            end
            ST_ERR2: resp = HRESP_ERROR;
            default: ;
        endcase

        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (readyout) begin
            if (accept) begin
                if (addr_err) begin
                    state_d = ST_ERR1;
                end else if (bus.s_ahb_write_i) begin
                    state_d = ST_WDATA;
                end else begin
                    state_d = ST_RDATA;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    iob_ahb2axis_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clock    (clk_i),
        .cke      (cke_i),
        .reset    (rst_i),
        .load     (load),
        .load_data(bus.s_ahb_wdata_i),
        .load_last(off_q == OFF_DATA_LAST),
        .tready   (bus.out_axis_tready_i),
        .tvalid   (bus.out_axis_tvalid_o),
        .tdata    (bus.out_axis_tdata_o),
        .tlast    (bus.out_axis_tlast_o),
        .full     (obuf_full)
    );

    // tready only in the completing cycle, so a pop never happens without the read finishing
    assign bus.in_axis_tready_o = pop_phase && bus.in_axis_tvalid_i && cke_i && !rst_i;
    assign bus.s_ahb_readyout_o = readyout;
    assign bus.s_ahb_resp_o     = resp;
    assign bus.s_ahb_rdata_o    = rdata;

endmodule

// File: tb/tb_iob_ahb2axis.sv
// Directed, table-driven bench for iob_ahb2axis plus hand-written pipelining/reset/error sequences.
// Expected values follow IOB_AHB2AXIS_ERR_EN when it is defined for the build.
module tb_iob_ahb2axis;

`ifdef IOB_AHB2AXIS_ERR_EN
    localparam logic ERR_BUILD = 1'b1;
`else
    localparam logic ERR_BUILD = 1'b0;
`endif

    typedef struct {
        logic        write;
        logic [1:0]  off;
        logic [31:0] wdata;
        logic        in_valid;
        logic [31:0] in_data;
        logic        in_last;
        int          exp_waits;
        logic        exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_in_ready;
        logic        exp_tvalid;
        logic [31:0] exp_tdata;
        logic        exp_tlast;
    } vec_t;

    logic        clk = 1'b0;
    logic        cke;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    int          in_ready_cycles = 0;
    logic [32:0] beats[$];
    vec_t        vecs[7];

    iob_ahb2axis_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    assign bus.s_ahb_ready_i = bus.s_ahb_readyout_o;

    iob_ahb2axis #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk_i(clk),
        .cke_i(cke),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.out_axis_tvalid_o && bus.out_axis_tready_i)
            beats.push_back({bus.out_axis_tlast_o, bus.out_axis_tdata_o});
        if (bus.in_axis_tready_o)
            in_ready_cycles <= in_ready_cycles + 1;
        if (bus.in_axis_tready_o && bus.in_axis_tvalid_i)
            pops <= pops + 1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.s_ahb_sel_i   = 1'b0;
        bus.s_ahb_trans_i = 2'b00;
        bus.s_ahb_write_i = 1'b0;
    endtask

    task automatic addr_phase(input logic wr, input logic [1:0] off, input logic [2:0] size, input logic [1:0] trans);
        bus.s_ahb_sel_i   = 1'b1;
        bus.s_ahb_trans_i = trans;
        bus.s_ahb_addr_i  = {28'h0, off, 2'b00};
        bus.s_ahb_write_i = wr;
        bus.s_ahb_size_i  = size;
    endtask

    // Returns at the negedge of the completing data-phase cycle
    task automatic wait_ready(input logic wr, input int release_after, output int waits,
                              output logic resp_first, output logic resp_last,
                              output logic [31:0] rd, output logic rdy_in);
        logic done;
        done = 1'b0;
        waits = 0;
        resp_first = 1'b0;
        resp_last = 1'b0;
        rd = '0;
        rdy_in = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) resp_first = bus.s_ahb_resp_o;
            if (bus.s_ahb_readyout_o) begin
                resp_last = bus.s_ahb_resp_o;
                rd = bus.s_ahb_rdata_o;
                rdy_in = bus.in_axis_tready_o;
                done = 1'b1;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
            if (waits == release_after) begin
                if (wr) bus.out_axis_tready_i = 1'b1;
                else bus.in_axis_tvalid_i = 1'b1;
            end
        end
        if (!done) checkOutput("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_xfer(input logic wr, input logic [1:0] off, input logic [2:0] size,
                           input logic [31:0] wd, input int release_after, output int waits,
                           output logic resp_first, output logic resp_last,
                           output logic [31:0] rd, output logic rdy_in);
        addr_phase(wr, off, size, 2'b10);
        @(posedge clk);
        #1;
        bus_idle();
        bus.s_ahb_wdata_i = wd;
        wait_ready(wr, release_after, waits, resp_first, resp_last, rd, rdy_in);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx);
        int          waits;
        logic        rf;
        logic        rl;
        logic [31:0] rd;
        logic        ri;
        vec_t        v;
        v = vecs[idx];
        bus.in_axis_tvalid_i = v.in_valid;
        bus.in_axis_tdata_i  = v.in_data;
        bus.in_axis_tlast_i  = v.in_last;
        do_xfer(v.write, v.off, 3'd2, v.wdata, -1, waits, rf, rl, rd, ri);
        checkOutput($sformatf("vec%0d_waits", idx), 64'(waits), 64'(v.exp_waits));
        checkOutput($sformatf("vec%0d_resp", idx), 64'(rl), 64'(v.exp_resp));
        checkOutput($sformatf("vec%0d_in_ready", idx), 64'(ri), 64'(v.exp_in_ready));
        if (!v.write)
            checkOutput($sformatf("vec%0d_rdata", idx), 64'(rd), 64'(v.exp_rdata));
        checkOutput($sformatf("vec%0d_tvalid", idx), 64'(bus.out_axis_tvalid_o), 64'(v.exp_tvalid));
        if (v.exp_tvalid) begin
            checkOutput($sformatf("vec%0d_tdata", idx), 64'(bus.out_axis_tdata_o), 64'(v.exp_tdata));
            checkOutput($sformatf("vec%0d_tlast", idx), 64'(bus.out_axis_tlast_o), 64'(v.exp_tlast));
        end
        bus.in_axis_tvalid_i = 1'b0;
        bus.in_axis_tlast_i  = 1'b0;
    endtask

    initial begin
        int          waits;
        logic        rf;
        logic        rl;
        logic [31:0] rd;
        logic        ri;
        int          pops0;
        int          rdy0;

        vecs[0] = '{write:1'b1, off:2'd0, wdata:32'hA5A5_0001, in_valid:1'b0, in_data:32'h0, in_last:1'b0,
                    exp_waits:0, exp_resp:1'b0, exp_rdata:32'h0, exp_in_ready:1'b0,
                    exp_tvalid:1'b1, exp_tdata:32'hA5A5_0001, exp_tlast:1'b0};
        vecs[1] = '{write:1'b1, off:2'd1, wdata:32'hDEAD_BEEF, in_valid:1'b0, in_data:32'h0, in_last:1'b0,
                    exp_waits:0, exp_resp:1'b0, exp_rdata:32'h0, exp_in_ready:1'b0,
                    exp_tvalid:1'b1, exp_tdata:32'hDEAD_BEEF, exp_tlast:1'b1};
        vecs[2] = '{write:1'b0, off:2'd0, wdata:32'h0, in_valid:1'b1, in_data:32'hCAFE_F00D, in_last:1'b0,
                    exp_waits:0, exp_resp:1'b0, exp_rdata:32'hCAFE_F00D, exp_in_ready:1'b1,
                    exp_tvalid:1'b0, exp_tdata:32'h0, exp_tlast:1'b0};
        vecs[3] = '{write:1'b0, off:2'd2, wdata:32'h0, in_valid:1'b1, in_data:32'h0000_0099, in_last:1'b0,
                    exp_waits:0, exp_resp:1'b0, exp_rdata:32'h0000_0001, exp_in_ready:1'b0,
                    exp_tvalid:1'b0, exp_tdata:32'h0, exp_tlast:1'b0};
        vecs[4] = '{write:1'b0, off:2'd3, wdata:32'h0, in_valid:1'b0, in_data:32'h0, in_last:1'b0,
                    exp_waits:(ERR_BUILD ? 1 : 0), exp_resp:ERR_BUILD, exp_rdata:32'h0, exp_in_ready:1'b0,
                    exp_tvalid:1'b0, exp_tdata:32'h0, exp_tlast:1'b0};
        vecs[5] = '{write:1'b1, off:2'd2, wdata:32'h0000_0055, in_valid:1'b0, in_data:32'h0, in_last:1'b0,
                    exp_waits:(ERR_BUILD ? 1 : 0), exp_resp:ERR_BUILD, exp_rdata:32'h0, exp_in_ready:1'b0,
                    exp_tvalid:1'b0, exp_tdata:32'h0, exp_tlast:1'b0};
        vecs[6] = '{write:1'b0, off:2'd1, wdata:32'h0, in_valid:1'b1, in_data:32'h0BAD_C0DE, in_last:1'b1,
                    exp_waits:0, exp_resp:1'b0, exp_rdata:32'h0BAD_C0DE, exp_in_ready:1'b1,
                    exp_tvalid:1'b0, exp_tdata:32'h0, exp_tlast:1'b0};

        cke = 1'b1;
        rst = 1'b1;
        bus_idle();
        bus.s_ahb_addr_i      = '0;
        bus.s_ahb_size_i      = 3'd2;
        bus.s_ahb_wdata_i     = '0;
        bus.s_ahb_wstrb_i     = '1;
        bus.out_axis_tready_i = 1'b1;
        bus.in_axis_tvalid_i  = 1'b0;
        bus.in_axis_tdata_i   = '0;
        bus.in_axis_tlast_i   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_readyout", 64'(bus.s_ahb_readyout_o), 64'd1);
        checkOutput("reset_resp", 64'(bus.s_ahb_resp_o), 64'd0);
        checkOutput("reset_rdata", 64'(bus.s_ahb_rdata_o), 64'd0);
        checkOutput("reset_tvalid", 64'(bus.out_axis_tvalid_o), 64'd0);
        checkOutput("reset_tdata", 64'(bus.out_axis_tdata_o), 64'd0);
        checkOutput("reset_tlast", 64'(bus.out_axis_tlast_o), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_axis_tready_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) applyStimulus(i);
        @(posedge clk);
        #1;

        $display("[TB] pipelined writes with back-pressure");
        beats.delete();
        bus.out_axis_tready_i = 1'b0;
        addr_phase(1'b1, 2'd0, 3'd2, 2'b10);
        @(posedge clk);
        #1;
        addr_phase(1'b1, 2'd0, 3'd2, 2'b11);
        bus.s_ahb_wdata_i = 32'h1111_0001;
        @(negedge clk);
        checkOutput("pipe_w1_ready", 64'(bus.s_ahb_readyout_o), 64'd1);
        @(posedge clk);
        #1;
        addr_phase(1'b1, 2'd1, 3'd2, 2'b11);
        bus.s_ahb_wdata_i = 32'h1111_0002;
        wait_ready(1'b1, 5, waits, rf, rl, rd, ri);
        checkOutput("pipe_w2_waits", 64'(waits), 64'd5);
        @(posedge clk);
        #1;
        bus_idle();
        bus.s_ahb_wdata_i = 32'h1111_0003;
        @(negedge clk);
        checkOutput("pipe_w3_ready", 64'(bus.s_ahb_readyout_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pipe_beat_count", 64'(beats.size()), 64'd3);
        if (beats.size() == 3) begin
            checkOutput("pipe_beat0", 64'(beats[0]), 64'({1'b0, 32'h1111_0001}));
            checkOutput("pipe_beat1", 64'(beats[1]), 64'({1'b0, 32'h1111_0002}));
            checkOutput("pipe_beat2", 64'(beats[2]), 64'({1'b1, 32'h1111_0003}));
        end

        $display("[TB] read with empty input stream");
        pops0 = pops;
        rdy0 = in_ready_cycles;
        bus.in_axis_tdata_i = 32'h1234_5678;
        do_xfer(1'b0, 2'd0, 3'd2, 32'h0, 4, waits, rf, rl, rd, ri);
        checkOutput("rd_wait_count", 64'(waits), 64'd4);
        checkOutput("rd_wait_rdata", 64'(rd), 64'h1234_5678);
        checkOutput("rd_wait_in_ready", 64'(ri), 64'd1);
        checkOutput("rd_wait_pops", 64'(pops - pops0), 64'd1);
        checkOutput("rd_wait_ready_cycles", 64'(in_ready_cycles - rdy0), 64'd1);
        bus.in_axis_tvalid_i = 1'b0;

        $display("[TB] status read with full out buffer");
        beats.delete();
        bus.out_axis_tready_i = 1'b0;
        do_xfer(1'b1, 2'd0, 3'd2, 32'h7777_0007, -1, waits, rf, rl, rd, ri);
        checkOutput("stat_fill_waits", 64'(waits), 64'd0);
        bus.in_axis_tvalid_i = 1'b1;
        bus.in_axis_tlast_i  = 1'b1;
        bus.in_axis_tdata_i  = 32'h5555_AAAA;
        pops0 = pops;
        do_xfer(1'b0, 2'd2, 3'd2, 32'h0, -1, waits, rf, rl, rd, ri);
        checkOutput("stat_rdata", 64'(rd), 64'h7);
        checkOutput("stat_waits", 64'(waits), 64'd0);
        checkOutput("stat_no_pop", 64'(pops - pops0), 64'd0);
        bus.in_axis_tvalid_i  = 1'b0;
        bus.in_axis_tlast_i   = 1'b0;
        bus.out_axis_tready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stat_drained", 64'(bus.out_axis_tvalid_o), 64'd0);
        checkOutput("stat_beat_count", 64'(beats.size()), 64'd1);
        if (beats.size() == 1)
            checkOutput("stat_beat", 64'(beats[0]), 64'({1'b0, 32'h7777_0007}));

        $display("[TB] reset during write wait state");
        beats.delete();
        bus.out_axis_tready_i = 1'b0;
        do_xfer(1'b1, 2'd0, 3'd2, 32'h2222_0001, -1, waits, rf, rl, rd, ri);
        addr_phase(1'b1, 2'd0, 3'd2, 2'b10);
        @(posedge clk);
        #1;
        bus_idle();
        bus.s_ahb_wdata_i = 32'h2222_0002;
        @(negedge clk);
        checkOutput("rst_pre_wait", 64'(bus.s_ahb_readyout_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_readyout", 64'(bus.s_ahb_readyout_o), 64'd1);
        checkOutput("rst_resp", 64'(bus.s_ahb_resp_o), 64'd0);
        checkOutput("rst_rdata", 64'(bus.s_ahb_rdata_o), 64'd0);
        checkOutput("rst_tvalid", 64'(bus.out_axis_tvalid_o), 64'd0);
        checkOutput("rst_tdata", 64'(bus.out_axis_tdata_o), 64'd0);
        @(posedge clk);
        #1;
        bus.out_axis_tready_i = 1'b1;
        do_xfer(1'b1, 2'd0, 3'd2, 32'h3333_0003, -1, waits, rf, rl, rd, ri);
        checkOutput("rst_after_waits", 64'(waits), 64'd0);
        checkOutput("rst_after_tvalid", 64'(bus.out_axis_tvalid_o), 64'd1);
        checkOutput("rst_after_tdata", 64'(bus.out_axis_tdata_o), 64'h3333_0003);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_beat_count", 64'(beats.size()), 64'd1);
        if (beats.size() == 1)
            checkOutput("rst_beat", 64'(beats[0]), 64'({1'b0, 32'h3333_0003}));

        $display("[TB] halfword write");
        beats.delete();
        do_xfer(1'b1, 2'd0, 3'd1, 32'h0000_BEEF, -1, waits, rf, rl, rd, ri);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("half_waits", 64'(waits), ERR_BUILD ? 64'd1 : 64'd0);
        checkOutput("half_resp_first", 64'(rf), 64'(ERR_BUILD));
        checkOutput("half_resp_last", 64'(rl), 64'(ERR_BUILD));
        checkOutput("half_beat_count", 64'(beats.size()), ERR_BUILD ? 64'd0 : 64'd1);
        if (beats.size() == 1)
            checkOutput("half_beat", 64'(beats[0]), 64'({1'b0, 32'h0000_BEEF}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
